// File: rtl/sixteen_rr_arbiter_if.sv
// rtl/sixteen_rr_arbiter_if.sv - request/grant/select bundle between requesters and the arbiter
interface sixteen_rr_arbiter_if;
    logic [0:15] req;
    logic [0:15] grant;
    logic [3:0]  sel;
    logic        valid;
    logic        preempt;

    modport master (output req, input grant, input sel, input valid, input preempt);
    modport slave  (input req, output grant, output sel, output valid, output preempt);
endinterface

// File: rtl/sixteen_rr_arbiter.sv
// rtl/sixteen_rr_arbiter.sv - 16-way round-robin arbiter driving the SixteenMux select
module sixteen_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    sixteen_rr_arbiter_if.slave  bus
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

    state_t      state_q, state_d;
    logic [3:0]  cur_q, cur_d;
    logic [7:0]  hold_q, hold_d;
    logic [0:15] grant_q, grant_d;
    logic [3:0]  sel_q, sel_d;
    logic        valid_q, valid_d;
    logic        preempt_q, preempt_d;

    logic [3:0]  win;
    logic        others;
    logic        take;

    // Search starts just past the last grantee and ends on it, so it is always served last.
    function automatic logic [3:0] rr_pick(input logic [0:15] r, input logic [3:0] start);
        logic [3:0] idx;
        logic       found;
        rr_pick = start;
        found   = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            idx = start + 4'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    function automatic logic [0:15] onehot(input logic [3:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        hold_d    = hold_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        valid_d   = valid_q;
        preempt_d = 1'b0;
        take      = 1'b0;

        win    = rr_pick(bus.req, cur_q);
        others = |(bus.req & ~onehot(cur_q));

        case (state_q)
            IDLE: begin
                if (|bus.req) take = 1'b1;
            end
            BUSY: begin
                if (!bus.req[cur_q]) begin
                    if (others) begin
                        take = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        valid_d = 1'b0;
                        hold_d  = '0;
                    end
                end else if (hold_q == HOLD_LIMIT && others) begin
                    take      = 1'b1;
                    preempt_d = 1'b1;
                end else if (hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            state_d = BUSY;
            cur_d   = win;
            sel_d   = win;
            grant_d = onehot(win);
            valid_d = 1'b1;
            hold_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cur_q     <= 4'd15;
            hold_q    <= '0;
            grant_q   <= '0;
            sel_q     <= '0;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            hold_q    <= hold_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            valid_q   <= valid_d;
            preempt_q <= preempt_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.sel     = sel_q;
    assign bus.valid   = valid_q;
    assign bus.preempt = preempt_q;

endmodule

// File: tb/tb_sixteen_rr_arbiter.sv
// tb/tb_sixteen_rr_arbiter.sv - directed self-checking bench for sixteen_rr_arbiter
module tb_sixteen_rr_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    sixteen_rr_arbiter_if a8 ();
    sixteen_rr_arbiter_if a1 ();

    sixteen_rr_arbiter #(.MAX_HOLD(8)) u_dut8 (.clk(clk), .rst(rst), .bus(a8.slave));
    sixteen_rr_arbiter #(.MAX_HOLD(1)) u_dut1 (.clk(clk), .rst(rst), .bus(a1.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Bit i of a [0:15] vector is the i-th bit from the MSB of its packed value.
    function automatic logic [15:0] oh(input int i);
        oh = 16'h8000 >> i;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk8(input string tag, input logic [15:0] g, input logic [3:0] s,
                        input logic v, input logic p);
        chk({tag, ".grant"},   32'(a8.grant),   32'(g));
        chk({tag, ".sel"},     32'(a8.sel),     32'(s));
        chk({tag, ".valid"},   32'(a8.valid),   32'(v));
        chk({tag, ".preempt"}, 32'(a8.preempt), 32'(p));
    endtask

    task automatic chk1(input string tag, input logic [15:0] g, input logic [3:0] s,
                        input logic v, input logic p);
        chk({tag, ".grant"},   32'(a1.grant),   32'(g));
        chk({tag, ".sel"},     32'(a1.sel),     32'(s));
        chk({tag, ".valid"},   32'(a1.valid),   32'(v));
        chk({tag, ".preempt"}, 32'(a1.preempt), 32'(p));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        a8.req   = '0;
        a1.req   = '0;

        #2;
        chk8("reset8", 16'h0, 4'd0, 1'b0, 1'b0);
        chk1("reset1", 16'h0, 4'd0, 1'b0, 1'b0);
        #10 rst = 1'b1;
        @(negedge clk);
        tick();
        chk8("idle_after_reset", 16'h0, 4'd0, 1'b0, 1'b0);

        // single request on bit 0, then drop
        a8.req = oh(0);
        tick();
        chk8("single_grant", 16'h8000, 4'd0, 1'b1, 1'b0);
        a8.req = '0;
        tick();
        chk8("single_drop", 16'h0, 4'd0, 1'b0, 1'b0);

        // back-to-back release 4 -> 6
        a8.req = oh(4) | oh(6);
        tick();
        chk8("b2b_first", oh(4), 4'd4, 1'b1, 1'b0);
        tick();
        chk8("b2b_hold", oh(4), 4'd4, 1'b1, 1'b0);
        a8.req = oh(6);
        tick();
        chk8("b2b_switch", oh(6), 4'd6, 1'b1, 1'b0);
        a8.req = '0;
        tick();
        chk8("b2b_idle", 16'h0, 4'd6, 1'b0, 1'b0);

        // hold limit: bit 3 granted, bit 5 joins one cycle later
        a8.req = oh(3);
        tick();
        chk8("hold_g", oh(3), 4'd3, 1'b1, 1'b0);
        a8.req = oh(3) | oh(5);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk8("hold_keep", oh(3), 4'd3, 1'b1, 1'b0);
        end
        tick();
        chk8("hold_rotate", oh(5), 4'd5, 1'b1, 1'b1);
        tick();
        chk8("hold_after", oh(5), 4'd5, 1'b1, 1'b0);

        // lone requester keeps the grant indefinitely
        a8.req = oh(3);
        tick();
        chk8("lone_back", oh(3), 4'd3, 1'b1, 1'b0);
        for (int i = 0; i < 310; i++) begin
            tick();
            chk("lone_sel", 32'(a8.sel), 32'd3);
            chk("lone_preempt", 32'(a8.preempt), 32'd0);
        end
        a8.req = '0;
        tick();
        chk8("lone_idle", 16'h0, 4'd3, 1'b0, 1'b0);

        // release coinciding with timeout counts as a release
        a8.req = oh(1);
        tick();
        chk8("rt_g", oh(1), 4'd1, 1'b1, 1'b0);
        a8.req = oh(1) | oh(9);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk8("rt_keep", oh(1), 4'd1, 1'b1, 1'b0);
        end
        a8.req = oh(9);
        tick();
        chk8("rt_release", oh(9), 4'd9, 1'b1, 1'b0);

        // asynchronous reset mid-grant
        #2 rst = 1'b0;
        #1;
        chk8("midreset", 16'h0, 4'd0, 1'b0, 1'b0);
        a8.req = '0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk8("midreset_idle", 16'h0, 4'd0, 1'b0, 1'b0);

        // MAX_HOLD=1 wrap across bits 2, 10, 15
        a1.req = oh(2) | oh(10) | oh(15);
        tick();
        chk1("wrap_first", oh(2), 4'd2, 1'b1, 1'b0);
        tick();
        chk1("wrap_10", oh(10), 4'd10, 1'b1, 1'b1);
        tick();
        chk1("wrap_15", oh(15), 4'd15, 1'b1, 1'b1);
        tick();
        chk1("wrap_2", oh(2), 4'd2, 1'b1, 1'b1);
        tick();
        chk1("wrap_10b", oh(10), 4'd10, 1'b1, 1'b1);
        a1.req = '0;
        tick();
        chk1("wrap_idle", 16'h0, 4'd10, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
